// File: rtl/alu_share_arbiter.sv
// Shares one ALU_32bit between two valid/ready requesters. One operation is in
// flight at a time; results come back on a tagged, registered response channel.

module ALU_32bit (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [2:0]  i_alu_sel,
  output logic [31:0] o_alu_out,
  output logic        o_zero,
  output logic        o_neg,
  output logic        o_carry,
  output logic        o_ovf
);
  logic [32:0] w_sum;

  always_comb begin
    w_sum     = 33'd0;
    o_alu_out = 32'd0;
    o_carry   = 1'b0;
    o_ovf     = 1'b0;
    case (i_alu_sel)
      3'b000: o_alu_out = ~i_a;
      3'b001: o_alu_out = i_a | i_b;
      3'b010: o_alu_out = i_a & i_b;
      3'b011: begin
        o_alu_out = -i_a;
        o_ovf     = (i_a == 32'h8000_0000);
      end
      3'b100: begin
        w_sum     = {1'b0, i_a} + {1'b0, i_b};
        o_alu_out = w_sum[31:0];
        o_carry   = w_sum[32];
        o_ovf     = (i_a[31] == i_b[31]) && (w_sum[31] != i_a[31]);
      end
      3'b101: begin
        // carry set means no borrow (a >= b unsigned)
        w_sum     = {1'b0, i_a} + {1'b0, ~i_b} + 33'd1;
        o_alu_out = w_sum[31:0];
        o_carry   = w_sum[32];
        o_ovf     = (i_a[31] != i_b[31]) && (w_sum[31] != i_a[31]);
      end
      3'b110:  o_alu_out = i_a * i_b;
      default: o_alu_out = i_a ^ i_b;
    endcase
    o_zero = (o_alu_out == 32'd0);
    o_neg  = o_alu_out[31];
  end
endmodule

module alu_share_arbiter #(
  parameter int RR_EN = 1,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_r0_valid,
  input  logic             i_r1_valid,
  output logic             o_r0_ready,
  output logic             o_r1_ready,
  input  logic [31:0]      i_r0_a,
  input  logic [31:0]      i_r0_b,
  input  logic [31:0]      i_r1_a,
  input  logic [31:0]      i_r1_b,
  input  logic [2:0]       i_r0_op,
  input  logic [2:0]       i_r1_op,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic             o_rsp_id,
  output logic [31:0]      o_rsp_result,
  output logic             o_rsp_zero,
  output logic             o_rsp_neg,
  output logic             o_rsp_carry,
  output logic             o_rsp_ovf,
  output logic [CNT_W-1:0] o_r0_done_cnt,
  output logic [CNT_W-1:0] o_r1_done_cnt
);
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t            r_state;
  logic              r_armed;
  logic              r_last;
  logic              r_id;
  logic [31:0]       r_a, r_b;
  logic [2:0]        r_op;
  logic              r_rsp_valid, r_rsp_id;
  logic [31:0]       r_rsp_result;
  logic              r_rsp_zero, r_rsp_neg, r_rsp_carry, r_rsp_ovf;
  logic [CNT_W-1:0]  r_cnt0, r_cnt1;

  logic              w_gnt1, w_accept;
  logic [31:0]       w_alu_out;
  logic              w_zero, w_neg, w_carry, w_ovf;

  always_comb begin
    w_gnt1 = i_r1_valid;
    if (i_r0_valid && i_r1_valid) w_gnt1 = (RR_EN != 0) ? ~r_last : 1'b0;
  end

  // r_armed keeps both readies low until the first edge after reset release
  assign w_accept   = (r_state == S_IDLE) && r_armed && (i_r0_valid || i_r1_valid);
  assign o_r0_ready = w_accept && !w_gnt1;
  assign o_r1_ready = w_accept && w_gnt1;

  ALU_32bit u_alu (
    .i_a       (r_a),
    .i_b       (r_b),
    .i_alu_sel (r_op),
    .o_alu_out (w_alu_out),
    .o_zero    (w_zero),
    .o_neg     (w_neg),
    .o_carry   (w_carry),
    .o_ovf     (w_ovf)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_armed      <= 1'b0;
      r_last       <= 1'b1;
      r_id         <= 1'b0;
      r_a          <= 32'd0;
      r_b          <= 32'd0;
      r_op         <= 3'd0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= 32'd0;
      r_rsp_zero   <= 1'b0;
      r_rsp_neg    <= 1'b0;
      r_rsp_carry  <= 1'b0;
      r_rsp_ovf    <= 1'b0;
      r_cnt0       <= '0;
      r_cnt1       <= '0;
    end else begin
      r_armed <= 1'b1;
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_a     <= w_gnt1 ? i_r1_a : i_r0_a;
          r_b     <= w_gnt1 ? i_r1_b : i_r0_b;
          r_op    <= w_gnt1 ? i_r1_op : i_r0_op;
          r_id    <= w_gnt1;
          r_last  <= w_gnt1;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_rsp_result <= w_alu_out;
          r_rsp_zero   <= w_zero;
          r_rsp_neg    <= w_neg;
          r_rsp_carry  <= w_carry;
          r_rsp_ovf    <= w_ovf;
          r_rsp_id     <= r_id;
          r_rsp_valid  <= 1'b1;
          r_state      <= S_RESP;
        end
        S_RESP: if (i_rsp_ready) begin
          r_rsp_valid <= 1'b0;
          if (r_rsp_id) r_cnt1 <= r_cnt1 + CNT_W'(1);
          else          r_cnt0 <= r_cnt0 + CNT_W'(1);
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_rsp_valid   = r_rsp_valid;
  assign o_rsp_id      = r_rsp_id;
  assign o_rsp_result  = r_rsp_result;
  assign o_rsp_zero    = r_rsp_zero;
  assign o_rsp_neg     = r_rsp_neg;
  assign o_rsp_carry   = r_rsp_carry;
  assign o_rsp_ovf     = r_rsp_ovf;
  assign o_r0_done_cnt = r_cnt0;
  assign o_r1_done_cnt = r_cnt1;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a round-robin/16-bit instance and a fixed-priority/
// 2-bit-counter instance share stimulus; a negedge monitor scoreboards both.
`timescale 1ns/1ps
module tb_alu_share_arbiter;
  logic clk, i_rst_n;
  logic i_r0_valid, i_r1_valid, i_rsp_ready;
  logic [31:0] i_r0_a, i_r0_b, i_r1_a, i_r1_b;
  logic [2:0] i_r0_op, i_r1_op;

  logic a_r0_ready, a_r1_ready, a_rsp_valid, a_rsp_id, a_z, a_n, a_c, a_v;
  logic [31:0] a_res;
  logic [15:0] a_cnt0, a_cnt1;
  logic b_r0_ready, b_r1_ready, b_rsp_valid, b_rsp_id, b_z, b_n, b_c, b_v;
  logic [31:0] b_res;
  logic [1:0] b_cnt0, b_cnt1;

  alu_share_arbiter #(.RR_EN(1), .CNT_W(16)) dut_a (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_r0_valid(i_r0_valid), .i_r1_valid(i_r1_valid),
    .o_r0_ready(a_r0_ready), .o_r1_ready(a_r1_ready), .i_r0_a(i_r0_a), .i_r0_b(i_r0_b),
    .i_r1_a(i_r1_a), .i_r1_b(i_r1_b), .i_r0_op(i_r0_op), .i_r1_op(i_r1_op),
    .o_rsp_valid(a_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_id(a_rsp_id),
    .o_rsp_result(a_res), .o_rsp_zero(a_z), .o_rsp_neg(a_n), .o_rsp_carry(a_c),
    .o_rsp_ovf(a_v), .o_r0_done_cnt(a_cnt0), .o_r1_done_cnt(a_cnt1));

  alu_share_arbiter #(.RR_EN(0), .CNT_W(2)) dut_b (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_r0_valid(i_r0_valid), .i_r1_valid(i_r1_valid),
    .o_r0_ready(b_r0_ready), .o_r1_ready(b_r1_ready), .i_r0_a(i_r0_a), .i_r0_b(i_r0_b),
    .i_r1_a(i_r1_a), .i_r1_b(i_r1_b), .i_r0_op(i_r0_op), .i_r1_op(i_r1_op),
    .o_rsp_valid(b_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_id(b_rsp_id),
    .o_rsp_result(b_res), .o_rsp_zero(b_z), .o_rsp_neg(b_n), .o_rsp_carry(b_c),
    .o_rsp_ovf(b_v), .o_r0_done_cnt(b_cnt0), .o_r1_done_cnt(b_cnt1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {logic id; logic [2:0] op; logic [31:0] a; logic [31:0] b;} op_t;
  typedef struct {logic id; logic [31:0] res; logic z; logic n; logic c; logic v;} rsp_t;
  typedef struct {logic [2:0] op; logic [31:0] a; logic [31:0] b; logic [31:0] res;
                  logic z; logic n; logic c; logic v;} vec_t;

  int n_vec = 0, n_err = 0;
  op_t hs_q[2][$];
  rsp_t rsp_q[2][$];
  int unsigned mcnt[2][2];

  localparam logic [2:0] NOT_ = 3'd0, OR_ = 3'd1, AND_ = 3'd2, NEG_ = 3'd3,
                         ADD_ = 3'd4, SUB_ = 3'd5, MUL_ = 3'd6, XOR_ = 3'd7;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] pk(input rsp_t r);
    return {27'd0, r.id, r.res, r.z, r.n, r.c, r.v};
  endfunction

  // Reference ALU from arithmetic definitions: wide signed/unsigned math, range checks.
  function automatic rsp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    rsp_t r;
    longint sa, sb, full;
    longint unsigned ua, ub;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = {32'd0, a}; ub = {32'd0, b};
    full = 0;
    r.id = 1'b0; r.c = 1'b0; r.v = 1'b0; r.res = 32'd0;
    case (op)
      NOT_: r.res = ~a;
      OR_:  r.res = a | b;
      AND_: r.res = a & b;
      NEG_: begin full = -sa; r.res = full[31:0]; r.v = (full > 64'sd2147483647); end
      ADD_: begin
        full = sa + sb; r.res = full[31:0];
        r.c = ((ua + ub) > 64'hFFFF_FFFF);
        r.v = (full > 64'sd2147483647) || (full < -64'sd2147483648);
      end
      SUB_: begin
        full = sa - sb; r.res = full[31:0];
        r.c = (ua >= ub);
        r.v = (full > 64'sd2147483647) || (full < -64'sd2147483648);
      end
      MUL_: begin full = sa * sb; r.res = full[31:0]; end
      default: r.res = a ^ b;
    endcase
    r.z = (r.res == 32'd0);
    r.n = r.res[31];
    return r;
  endfunction

  task automatic mon(input int w, input logic rd0, input logic rd1, input logic rv,
                     input logic rid, input logic [31:0] res, input logic z, input logic n,
                     input logic c, input logic v, input logic [15:0] c0, input logic [15:0] c1,
                     input int unsigned msk);
    op_t o;
    rsp_t got, e;
    if (rd0 || rd1) chk($sformatf("dut%0d_ready_rule", w), {62'd0, rd0 && rd1, rv}, 64'd0);
    if (rd0 && i_r0_valid) hs_q[w].push_back('{1'b0, i_r0_op, i_r0_a, i_r0_b});
    if (rd1 && i_r1_valid) hs_q[w].push_back('{1'b1, i_r1_op, i_r1_a, i_r1_b});
    if (rv && i_rsp_ready) begin
      got = '{rid, res, z, n, c, v};
      rsp_q[w].push_back(got);
      chk($sformatf("dut%0d_cnt", w), {32'd0, c1, c0},
          {32'd0, 16'(mcnt[w][1] & msk), 16'(mcnt[w][0] & msk)});
      if (hs_q[w].size() == 0) begin
        chk($sformatf("dut%0d_unexpected_rsp", w), 64'd1, 64'd0);
      end else begin
        o = hs_q[w].pop_front();
        e = model(o.op, o.a, o.b);
        e.id = o.id;
        chk($sformatf("dut%0d_scoreboard", w), pk(got), pk(e));
        mcnt[w][o.id ? 1 : 0]++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (i_rst_n) begin
      mon(0, a_r0_ready, a_r1_ready, a_rsp_valid, a_rsp_id, a_res, a_z, a_n, a_c, a_v,
          a_cnt0, a_cnt1, 32'hFFFF);
      mon(1, b_r0_ready, b_r1_ready, b_rsp_valid, b_rsp_id, b_res, b_z, b_n, b_c, b_v,
          {14'd0, b_cnt0}, {14'd0, b_cnt1}, 32'h3);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_model();
    for (int w = 0; w < 2; w++) begin
      hs_q[w].delete();
      rsp_q[w].delete();
      mcnt[w][0] = 0;
      mcnt[w][1] = 0;
    end
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0; i_r0_valid = 1'b0; i_r1_valid = 1'b0; i_rsp_ready = 1'b1;
    #1 clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    i_rst_n = 1'b1;
    tick();
  endtask

  task automatic set_req(input int id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (id == 0) begin i_r0_valid = 1'b1; i_r0_op = op; i_r0_a = a; i_r0_b = b; end
    else         begin i_r1_valid = 1'b1; i_r1_op = op; i_r1_a = a; i_r1_b = b; end
  endtask

  // Present an op on dut_a and return right after the handshake edge (EXEC cycle).
  task automatic send(input int id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bit hs, ok;
    ok = 1'b0;
    set_req(id, op, a, b);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      hs = (id == 0) ? a_r0_ready : a_r1_ready;
      tick();
      if (hs) begin ok = 1'b1; break; end
    end
    if (id == 0) i_r0_valid = 1'b0; else i_r1_valid = 1'b0;
    chk("send_handshake", {63'd0, ok}, 64'd1);
  endtask

  task automatic wait_rsp(output rsp_t r);
    bit ok;
    ok = 1'b0;
    r = '{1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 40; k++) begin
      if (rsp_q[0].size() > 0) begin r = rsp_q[0].pop_front(); ok = 1'b1; break; end
      tick();
    end
    chk("rsp_arrival", {63'd0, ok}, 64'd1);
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  vec_t tbl[13];
  rsp_t r, e;
  logic [5:0] ids_a, ids_b;
  logic [1:0] wrap_exp;
  bit hs0, hs1;

  initial begin
    tbl[0]  = '{ADD_, 32'd7,          32'd1,          32'd8,          1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{ADD_, 32'd5,          32'hFFFF_FFFB,  32'd0,          1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{SUB_, 32'd3,          32'd10,         32'hFFFF_FFF9,  1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{ADD_, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  1'b0, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{MUL_, 32'd1000,       32'd2000,       32'd2000000,    1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{XOR_, 32'd7,          32'd1,          32'd6,          1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{NOT_, 32'd0,          32'd9,          32'hFFFF_FFFF,  1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{OR_,  32'hF0,         32'h0F,         32'hFF,         1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{AND_, 32'hF0,         32'h3C,         32'h30,         1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{NEG_, 32'd5,          32'd0,          32'hFFFF_FFFB,  1'b0, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{SUB_, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1'b0, 1'b0, 1'b1, 1'b1};
    tbl[11] = '{AND_, 32'h0F,         32'hF0,         32'd0,          1'b1, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{NEG_, 32'h8000_0000,  32'd0,          32'h8000_0000,  1'b0, 1'b1, 1'b0, 1'b1};

    i_r0_a = 0; i_r0_b = 0; i_r1_a = 0; i_r1_b = 0; i_r0_op = 0; i_r1_op = 0;
    i_r1_valid = 1'b0; i_rsp_ready = 1'b1;
    i_r0_valid = 1'b1;
    i_rst_n = 1'b0;
    clear_model();

    // reset state, including readies held low while a request is pending
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs_a", {a_r0_ready, a_r1_ready, a_rsp_valid, a_rsp_id, a_z, a_n, a_c, a_v,
        a_res, a_cnt1[11:0], a_cnt0[11:0]}, 64'd0);
    chk("reset_outputs_b", {b_r0_ready, b_r1_ready, b_rsp_valid, b_rsp_id, b_res, b_cnt1, b_cnt0},
        64'd0);
    @(negedge clk);
    i_rst_n = 1'b1;
    #1 chk("ready_after_release", {63'd0, a_r0_ready}, 64'd0);
    tick();
    chk("ready_first_clock", {63'd0, a_r0_ready}, 64'd1);
    i_r0_valid = 1'b0;

    // basic issue with latency
    set_req(0, ADD_, 32'd7, 32'd1);
    #1 chk("basic_r0_ready", {62'd0, a_r0_ready, a_r1_ready}, 64'b10);
    tick();
    i_r0_valid = 1'b0;
    chk("basic_exec_no_rsp", {63'd0, a_rsp_valid}, 64'd0);
    tick();
    chk("basic_rsp", {26'd0, a_rsp_valid, a_rsp_id, a_z, a_res}, {26'd0, 1'b1, 1'b0, 1'b0, 32'd8});
    tick();
    chk("basic_cnt", {47'd0, a_rsp_valid, a_cnt0}, {47'd0, 1'b0, 16'd1});

    // table-driven ALU vectors via r0
    do_reset();
    for (int i = 0; i < 13; i++) begin
      send(0, tbl[i].op, tbl[i].a, tbl[i].b);
      wait_rsp(r);
      e = '{1'b0, tbl[i].res, tbl[i].z, tbl[i].n, tbl[i].c, tbl[i].v};
      chk($sformatf("vec%0d", i), pk(r), pk(e));
    end

    // tie: r0 first after reset, then r1
    do_reset();
    set_req(0, ADD_, 32'd5, 32'hFFFF_FFFB);
    set_req(1, SUB_, 32'd3, 32'd10);
    #1 chk("tie_grant", {62'd0, a_r0_ready, a_r1_ready}, 64'b10);
    tick();
    i_r0_valid = 1'b0;
    wait_rsp(r);
    chk("tie_first", {30'd0, r.id, r.z, r.res}, {30'd0, 1'b0, 1'b1, 32'd0});
    send(1, SUB_, 32'd3, 32'd10);
    wait_rsp(r);
    chk("tie_second", {30'd0, r.id, r.n, r.res}, {30'd0, 1'b1, 1'b1, 32'hFFFF_FFF9});

    // back-pressure with overflow, r1 held valid but never granted in RESP
    i_rsp_ready = 1'b0;
    send(1, ADD_, 32'h7FFF_FFFF, 32'd1);
    set_req(1, ADD_, 32'd1, 32'd1);
    tick();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp_hold%0d", k), {28'd0, a_rsp_valid, a_rsp_id, a_v, a_r1_ready, a_res},
          {28'd0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h8000_0000});
      tick();
    end
    i_rsp_ready = 1'b1;
    tick();
    chk("bp_release_idle", {62'd0, a_rsp_valid, a_r1_ready}, 64'b01);
    tick();
    i_r1_valid = 1'b0;
    wait_rsp(r);
    wait_rsp(r);
    chk("bp_next_op", {31'd0, r.id, r.res}, {31'd0, 1'b1, 32'd2});

    // MUL, then reset during EXEC of an r1 XOR
    send(0, MUL_, 32'd1000, 32'd2000);
    wait_rsp(r);
    chk("mul_result", {32'd0, r.res}, {32'd0, 32'd2000000});
    send(1, XOR_, 32'd7, 32'd1);
    i_rst_n = 1'b0;
    #1;
    chk("midreset_clear", {a_rsp_valid, a_rsp_id, a_z, a_n, a_c, a_v, a_r0_ready, a_r1_ready,
        a_res, a_cnt1[11:0], a_cnt0[11:0]}, 64'd0);
    clear_model();
    @(negedge clk);
    i_rst_n = 1'b1;
    repeat (6) tick();
    chk("midreset_no_rsp", {62'd0, (rsp_q[0].size() != 0), a_rsp_valid}, 64'd0);

    // counter wrap on the 2-bit instance
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send(0, ADD_, 32'(i), 32'd1);
      wait_rsp(r);
      wrap_exp = 2'(i + 1);
      chk($sformatf("wrap%0d", i), {62'd0, b_cnt0}, {62'd0, wrap_exp});
    end
    chk("wrap_wide_cnt", {48'd0, a_cnt0}, 64'd5);

    // fairness: both requesters held valid
    do_reset();
    set_req(0, ADD_, 32'd1, 32'd2);
    set_req(1, SUB_, 32'd9, 32'd4);
    for (int k = 0; k < 100; k++) begin
      if (rsp_q[0].size() >= 6) break;
      tick();
    end
    i_r0_valid = 1'b0;
    i_r1_valid = 1'b0;
    chk("fair_count", {62'd0, rsp_q[0].size() >= 6, rsp_q[1].size() >= 6}, 64'b11);
    if (rsp_q[0].size() >= 6 && rsp_q[1].size() >= 6) begin
      for (int j = 0; j < 6; j++) begin
        ids_a[j] = rsp_q[0][j].id;
        ids_b[j] = rsp_q[1][j].id;
      end
      chk("rr_sequence", {58'd0, ids_a}, {58'd0, 6'b101010});
      chk("fixed_sequence", {58'd0, ids_b}, 64'd0);
    end

    // randomized traffic with back-pressure, scoreboarded by the monitor
    do_reset();
    for (int cyc = 0; cyc < 900; cyc++) begin
      @(negedge clk);
      hs0 = a_r0_ready && i_r0_valid;
      hs1 = a_r1_ready && i_r1_valid;
      tick();
      if (!i_r0_valid || hs0) begin
        i_r0_valid = ($urandom_range(0, 2) != 0);
        i_r0_op = 3'($urandom_range(0, 7)); i_r0_a = rnd_opnd(); i_r0_b = rnd_opnd();
      end else if ($urandom_range(0, 15) == 0) i_r0_valid = 1'b0;
      if (!i_r1_valid || hs1) begin
        i_r1_valid = ($urandom_range(0, 2) != 0);
        i_r1_op = 3'($urandom_range(0, 7)); i_r1_a = rnd_opnd(); i_r1_b = rnd_opnd();
      end else if ($urandom_range(0, 15) == 0) i_r1_valid = 1'b0;
      i_rsp_ready = ($urandom_range(0, 3) != 0);
    end
    i_r0_valid = 1'b0;
    i_r1_valid = 1'b0;
    i_rsp_ready = 1'b1;
    repeat (10) tick();
    chk("rand_drained", {62'd0, hs_q[0].size() != 0, hs_q[1].size() != 0}, 64'd0);
    chk("rand_cnt_a", {32'd0, a_cnt1, a_cnt0}, {32'd0, 16'(mcnt[0][1]), 16'(mcnt[0][0])});
    chk("rand_cnt_b", {60'd0, b_cnt1, b_cnt0}, {60'd0, 2'(mcnt[1][1]), 2'(mcnt[1][0])});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
